hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Parametrised, stateful successor to the combinational hazard unit. Sits between ID/EX decode fields and the PC / IF-ID / ID-EX pipeline-register controls.
- Detects load-use hazards and stalls for a configurable number of cycles, inserting a bubble into ID/EX on each stalled cycle.
- Extends branch flush over a configurable number of cycles.
- Honours a global memory-busy freeze.
- Adds per-operand "used" qualifiers so no false stalls occur.

Parameters:
REG_AW, 2, register address width in bits.
LOAD_LAT, 1, load-use stall length in cycles (legal range 1..15).
FLUSH_CYC, 1, branch flush length in cycles (legal range 1..15).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  synchronous reset, active-low.
if_id_ra  in  REG_AW  source A address of the instruction in ID.
if_id_rb  in  REG_AW  source B address of the instruction in ID.
ra_used  in  1  instruction in ID reads ra.
rb_used  in  1  instruction in ID reads rb.
id_ex_rd  in  REG_AW  destination address of the instruction in EX.
id_ex_mem_read  in  1  instruction in EX is LDD, LDI or POP.
BT  in  1  branch taken, resolved in EX.
mem_busy  in  1  data/instruction memory not ready; freeze the whole front end.
pc_en  out  1  PC write enable.
if_id_en  out  1  IF/ID register enable.
id_ex_en  out  1  ID/EX register enable.
if_id_flush  out  1  clear IF/ID to NOP.
id_ex_flush  out  1  clear ID/EX to NOP (bubble).
hu_busy  out  1  high when state is not RUN.

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is synchronous and active-low.
- Reset: while rst_n=0 at an edge, state goes to RUN and both counters go to 0. Outputs are forced while rst_n=0: pc_en=0, if_id_en=0, id_ex_en=0, if_id_flush=1, id_ex_flush=1, hu_busy=0. Reset mid-stall or mid-flush abandons the sequence.
- Outputs are combinational from registered state plus current inputs. Detection adds zero cycles of latency.
- Hazard definition: haz = id_ex_mem_read & ((ra_used & id_ex_rd==if_id_ra) | (rb_used & id_ex_rd==if_id_rb)).
- Defaults: pc_en=1, if_id_en=1, id_ex_en=1, both flushes 0.
- Priority, highest first: reset > mem_busy > BT > haz/LSTALL.
- mem_busy=1 (freeze):
  - pc_en=0, if_id_en=0, id_ex_en=0, both flushes 0.
  - State and counters hold.
  - BT is held stable by the frozen EX stage, so it is acted on once mem_busy falls.
- RUN state:
  - If BT: if_id_flush=1 and id_ex_flush=1. If FLUSH_CYC>1, go to FLUSH with fcnt=FLUSH_CYC-1; otherwise stay in RUN.
  - Else if haz: pc_en=0, if_id_en=0, id_ex_flush=1. If LOAD_LAT>1, go to LSTALL with lcnt=LOAD_LAT-1.
- LSTALL state:
  - Outputs as in the RUN haz case, regardless of haz. This covers memory latency after the load has left EX.
  - lcnt decrements each cycle. When lcnt==1, return to RUN at the next edge.
  - Total stall is exactly LOAD_LAT cycles.
  - BT in LSTALL cancels the stall: apply the BT behaviour above and clear lcnt.
- FLUSH state:
  - if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_en=1. Hazard detection is suppressed.
  - fcnt decrements each cycle. When fcnt==1, return to RUN at the next edge.
  - BT again reloads fcnt=FLUSH_CYC-1.
  - Total flush is exactly FLUSH_CYC cycles.
- Counters are $clog2(16) = 4 bits wide. They never underflow and are 0 in RUN.
- hu_busy = (state != RUN).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with BT=1 and haz conditions true -> pc_en=0, flushes=1, hu_busy=0. After release with idle inputs -> pc_en=1, flushes=0.
- Load-use, LOAD_LAT=1: id_ex_mem_read=1, id_ex_rd=2, if_id_ra=2, ra_used=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle. Same inputs with ra_used=0 -> no stall.
- Load-use, LOAD_LAT=3: haz pulse for 1 cycle, then id_ex_mem_read=0 -> stall for 3 consecutive cycles, hu_busy=1 on cycles 2-3, RUN on cycle 4.
- Branch, FLUSH_CYC=2: BT pulse in RUN -> both flushes asserted for 2 cycles with pc_en=1. A haz arriving in cycle 2 is ignored.
- BT during LSTALL (LOAD_LAT=4, BT asserted on stall cycle 2) -> stall ends immediately, flush asserted, pc_en=1 the same cycle.
- mem_busy=1 for 3 cycles in the middle of LSTALL (LOAD_LAT=3) -> all enables 0, flushes 0, lcnt held. The stall resumes afterwards, and the total number of stalled (non-frozen) cycles is still 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stateful pipeline hazard controller. Handles load-use stalls
//                of LOAD_LAT cycles, branch flushes of FLUSH_CYC cycles and a
//                global memory-busy freeze of the front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int REG_AW    = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] if_id_ra,
  input  logic [REG_AW-1:0] if_id_rb,
  input  logic              ra_used,
  input  logic              rb_used,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_mem_read,
  input  logic              BT,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              hu_busy
);

  // Counters cover the full 1..15 legal range of both length parameters.
  localparam int CNT_W = $clog2(16);

  // Values loaded on entry; the entry cycle itself is the first stalled or
  // flushed cycle, so the remaining count is one less than the length.
  localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             haz_w;

  // Load-use hazard, qualified by whether ID actually reads each operand.
  assign haz_w = id_ex_mem_read &
                 ((ra_used & (id_ex_rd == if_id_ra)) |
                  (rb_used & (id_ex_rd == if_id_rb)));

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      lcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next-state and output decode; priority is reset, freeze, branch, stall.
  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    fcnt_d      = fcnt_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    hu_busy     = (state_q != RUN);

    if (!rst_n) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      hu_busy     = 1'b0;
    end else if (mem_busy) begin
      // Whole front end frozen; state and counters hold so a pending BT or
      // stall continues once memory is ready again.
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
    end else if (BT) begin
      // A taken branch overrides any stall and (re)starts the flush window.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      lcnt_d      = '0;
      if (FLUSH_CYC > 1) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (haz_w) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LSTALL;
              lcnt_d  = LOAD_RELOAD;
            end
          end
        end
        LSTALL: begin
          // Stall continues regardless of haz: the load has already left EX.
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          if (lcnt_q <= 1) begin
            state_d = RUN;
            lcnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q - 1'b1;
          end
        end
        FLUSH: begin
          // Hazard detection suppressed; the instructions being fetched are
          // wrong-path and get flushed anyway.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (fcnt_q <= 1) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - 1'b1;
          end
        end
        default: begin
          state_d = RUN;
          lcnt_d  = '0;
          fcnt_d  = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
